// File: rtl/imem_arbiter.sv
// Instruction-memory port arbiter: fetch owns the port in run mode, the UART loader owns it during a programming session.
// Optional build macro IMEM_WRITE_GUARD_EN drops loader writes above MAX_WORD and flags them on upg_err.
module imem_arbiter #(
  parameter int                ADDR_W      = 14,
  parameter logic [ADDR_W-1:0] MAX_WORD    = 14'h3FFF,
  parameter int                RELEASE_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              upg_req,
  input  logic              upg_wen,
  input  logic [ADDR_W-1:0] upg_addr,
  input  logic [31:0]       upg_wdata,
  input  logic              upg_done,
  output logic              upg_ack,
  output logic [15:0]       upg_cnt,
  output logic              upg_err,
  output logic              cpu_reset_o,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_PROG    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  rel_cnt_r;
  logic        pend_r;
  logic        req_q_r;
  logic        ready_r;
  logic        hold_r;
  logic        ack_r;
  logic [15:0] cnt_r;
  logic        wr_ok_s;
  logic        wr_go_s;
  logic        rise_s;
  logic        last_s;
  logic        unused_s;

`ifdef IMEM_WRITE_GUARD_EN
  logic err_r;

  assign wr_ok_s  = (upg_addr <= MAX_WORD);
  assign unused_s = ^{if_addr[1:0], if_addr[31:ADDR_W+2]};

  // Guard violation flag: sticky until reset or the start of the next session
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (state_r == ST_DRAIN) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_PROG) && upg_wen && !wr_ok_s) begin
      err_r <= 1'b1;
    end
  end

  assign upg_err = err_r;
`else
  assign wr_ok_s  = 1'b1;
  assign unused_s = ^{if_addr[1:0], if_addr[31:ADDR_W+2], MAX_WORD};
  assign upg_err  = 1'b0;
`endif

  assign wr_go_s = (state_r == ST_PROG) && upg_wen && wr_ok_s;
  // A new session request only counts as a fresh rising edge of upg_req
  assign rise_s  = upg_req && !req_q_r;
  assign last_s  = (rel_cnt_r == 4'(RELEASE_CYC - 1));

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (upg_req) state_nx_s = ST_DRAIN;
        else         state_nx_s = ST_RUN;
      end
      ST_DRAIN: state_nx_s = ST_PROG;
      ST_PROG: begin
        if (upg_done || !upg_req) state_nx_s = ST_RELEASE;
        else                      state_nx_s = ST_PROG;
      end
      ST_RELEASE: begin
        if (last_s) begin
          if (pend_r || rise_s) state_nx_s = ST_DRAIN;
          else                  state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_RELEASE;
        end
      end
      default: state_nx_s = ST_RUN;
    endcase
  end

  // Memory port mux: fetch in RUN, loader in PROG, idle otherwise
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = 32'h0000_0000;
    if (reset) begin
      mem_en = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          mem_en   = if_req;
          mem_addr = if_addr[ADDR_W+1:2];
        end
        ST_PROG: begin
          mem_en    = wr_go_s;
          mem_we    = wr_go_s;
          mem_addr  = upg_addr;
          mem_wdata = upg_wdata;
        end
        default: mem_en = 1'b0;
      endcase
    end
  end

  // State register and registered handshake outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_RUN;
      rel_cnt_r <= 4'd0;
      pend_r    <= 1'b0;
      req_q_r   <= 1'b0;
      ready_r   <= 1'b0;
      hold_r    <= 1'b0;
      ack_r     <= 1'b0;
      cnt_r     <= 16'h0000;
    end else begin
      state_r <= state_nx_s;
      req_q_r <= upg_req;
      ready_r <= (state_r == ST_RUN) && if_req;
      hold_r  <= (state_nx_s != ST_RUN);
      ack_r   <= wr_go_s;
      if (state_r == ST_RELEASE) begin
        rel_cnt_r <= rel_cnt_r + 4'd1;
        pend_r    <= pend_r || rise_s;
      end else begin
        rel_cnt_r <= 4'd0;
        pend_r    <= 1'b0;
      end
      if (state_r == ST_DRAIN) begin
        cnt_r <= 16'h0000;
      end else if (wr_go_s) begin
        cnt_r <= cnt_r + 16'h0001;
      end
    end
  end

  assign if_ready    = ready_r;
  assign if_rdata    = mem_rdata;
  assign if_stall    = hold_r;
  assign cpu_reset_o = hold_r;
  assign upg_ack     = ack_r;
  assign upg_cnt     = cnt_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, hand-written corner sequences, random run against a phase model.
module tb_imem_arbiter;

  localparam int ADDR_W = 14;
  localparam int REL    = 2;
`ifdef IMEM_WRITE_GUARD_EN
  localparam logic [13:0] MAXW  = 14'd15;
  localparam bit          GUARD = 1'b1;
`else
  localparam logic [13:0] MAXW  = 14'h3FFF;
  localparam bit          GUARD = 1'b0;
`endif

  logic        clock, reset;
  logic        if_req, if_ready, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        upg_req, upg_wen, upg_done, upg_ack, upg_err, cpu_reset_o;
  logic [13:0] upg_addr;
  logic [31:0] upg_wdata;
  logic [15:0] upg_cnt;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  imem_arbiter #(.ADDR_W(ADDR_W), .MAX_WORD(MAXW), .RELEASE_CYC(REL)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
    .upg_req(upg_req), .upg_wen(upg_wen), .upg_addr(upg_addr), .upg_wdata(upg_wdata), .upg_done(upg_done),
    .upg_ack(upg_ack), .upg_cnt(upg_cnt), .upg_err(upg_err), .cpu_reset_o(cpu_reset_o),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment memory: synchronous, one-cycle read latency, plus a bench preload port
  logic [31:0] env_mem [0:16383];
  logic        pre_we;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;
  always @(posedge clock) begin
    if (pre_we) env_mem[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rq, input logic [31:0] ia, input logic ur, input logic uw,
                       input logic [13:0] ua, input logic [31:0] ud, input logic dn);
    if_req = rq; if_addr = ia; upg_req = ur; upg_wen = uw; upg_addr = ua; upg_wdata = ud; upg_done = dn;
  endtask

  typedef struct {
    logic        if_req;  logic [31:0] if_addr; logic upg_req; logic upg_wen;
    logic [13:0] upg_addr; logic [31:0] upg_wdata; logic upg_done;
    logic        e_en; logic e_we; logic [13:0] e_addr;
    logic        e_ready; logic [31:0] e_rdata; logic e_hold; logic e_ack; logic [15:0] e_cnt;
  } vec_t;
  vec_t vt [12];

  // Phase model for the random run: 0 fetch owns port, 1 drain, 2 loader owns port, 3 release countdown
  int          m_phase, m_left;
  logic        m_pend, m_prev_req, m_err, m_ok;
  logic [15:0] m_cnt;
  logic [31:0] ref_mem [0:31];
  logic        x_en, x_we, x_ready, x_ack;
  logic [13:0] x_addr;
  logic [31:0] x_rdata;
  logic [4:0]  word;

  initial begin
    pre_we = 1'b0; pre_addr = 14'd0; pre_data = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0);
    reset = 1'b1;

    // Vector rows: inputs | comb en, we, addr | after edge ready, rdata, hold, ack, cnt
    vt[0]  = '{1'b1, 32'd0,  1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b1, 1'b0, 14'd0, 1'b1, 32'hA, 1'b0, 1'b0, 16'd0};
    vt[1]  = '{1'b1, 32'd4,  1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b1, 1'b0, 14'd1, 1'b1, 32'hB, 1'b0, 1'b0, 16'd0};
    vt[2]  = '{1'b1, 32'd8,  1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b1, 1'b0, 14'd2, 1'b1, 32'hC, 1'b0, 1'b0, 16'd0};
    vt[3]  = '{1'b1, 32'd12, 1'b1, 1'b0, 14'd0, 32'd0, 1'b0, 1'b1, 1'b0, 14'd3, 1'b1, 32'hD, 1'b1, 1'b0, 16'd0};
    vt[4]  = '{1'b1, 32'd16, 1'b1, 1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 32'h0, 1'b1, 1'b0, 16'd0};
    vt[5]  = '{1'b1, 32'd16, 1'b1, 1'b1, 14'd5, 32'd1, 1'b0, 1'b1, 1'b1, 14'd5, 1'b0, 32'h0, 1'b1, 1'b1, 16'd1};
    vt[6]  = '{1'b1, 32'd16, 1'b1, 1'b1, 14'd6, 32'd2, 1'b0, 1'b1, 1'b1, 14'd6, 1'b0, 32'h0, 1'b1, 1'b1, 16'd2};
    vt[7]  = '{1'b0, 32'd16, 1'b0, 1'b1, 14'd7, 32'd3, 1'b1, 1'b1, 1'b1, 14'd7, 1'b0, 32'h0, 1'b1, 1'b1, 16'd3};
    vt[8]  = '{1'b1, 32'd20, 1'b0, 1'b1, 14'd9, 32'd9, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 32'h0, 1'b1, 1'b0, 16'd3};
    vt[9]  = '{1'b1, 32'd20, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd3};
    vt[10] = '{1'b1, 32'd20, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b1, 1'b0, 14'd5, 1'b1, 32'd1, 1'b0, 1'b0, 16'd3};
    vt[11] = '{1'b0, 32'd20, 1'b0, 1'b0, 14'd0, 32'd0, 1'b0, 1'b0, 1'b0, 14'd5, 1'b0, 32'h0, 1'b0, 1'b0, 16'd3};

    // Preload words 0..3 and 16 while reset is held
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      pre_we = 1'b1;
      pre_addr = (i == 4) ? 14'd16 : 14'(i);
      pre_data = (i == 4) ? 32'h1616 : 32'(32'hA + i);
    end
    @(negedge clock);
    pre_we = 1'b0;
    #1;
    chk("rst_ready", 32'(if_ready), 32'd0);
    chk("rst_stall", 32'(if_stall), 32'd0);
    chk("rst_cpurst", 32'(cpu_reset_o), 32'd0);
    chk("rst_ack", 32'(upg_ack), 32'd0);
    chk("rst_cnt", 32'(upg_cnt), 32'd0);
    chk("rst_err", 32'(upg_err), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed vector table: fetch burst, session entry, three writes, release, fetch of written word
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(vt[i].if_req, vt[i].if_addr, vt[i].upg_req, vt[i].upg_wen, vt[i].upg_addr, vt[i].upg_wdata, vt[i].upg_done);
      #1;
      chk($sformatf("vec%0d_mem_en", i), 32'(mem_en), 32'(vt[i].e_en));
      chk($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vt[i].e_we));
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vt[i].e_addr));
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(if_ready), 32'(vt[i].e_ready));
      if (vt[i].e_ready) chk($sformatf("vec%0d_rdata", i), if_rdata, vt[i].e_rdata);
      chk($sformatf("vec%0d_stall", i), 32'(if_stall), 32'(vt[i].e_hold));
      chk($sformatf("vec%0d_cpurst", i), 32'(cpu_reset_o), 32'(vt[i].e_hold));
      chk($sformatf("vec%0d_ack", i), 32'(upg_ack), 32'(vt[i].e_ack));
      chk($sformatf("vec%0d_cnt", i), 32'(upg_cnt), 32'(vt[i].e_cnt));
      chk($sformatf("vec%0d_err", i), 32'(upg_err), 32'd0);
    end

    // upg_wen while in RUN is ignored
    @(negedge clock);
    drive(1'b0, 32'd20, 1'b0, 1'b1, 14'd2, 32'hFF, 1'b0);
    #1;
    chk("runwen_mem_we", 32'(mem_we), 32'd0);
    chk("runwen_mem_en", 32'(mem_en), 32'd0);
    @(posedge clock); #1;
    chk("runwen_ack", 32'(upg_ack), 32'd0);
    chk("runwen_cnt", 32'(upg_cnt), 32'd3);
    @(negedge clock);
    drive(1'b1, 32'd8, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0);
    @(posedge clock); #1;
    chk("runwen_rdata", if_rdata, 32'hC);

    // Reset in the middle of a programming session after two writes
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 14'd0, 32'h0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 14'd10, 32'h55, 1'b0);
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 14'd11, 32'h66, 1'b0);
    @(posedge clock); #1;
    chk("midrst_cnt_before", 32'(upg_cnt), 32'd2);
    chk("midrst_stall_before", 32'(if_stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_cnt", 32'(upg_cnt), 32'd0);
    chk("midrst_stall", 32'(if_stall), 32'd0);
    chk("midrst_cpurst", 32'(cpu_reset_o), 32'd0);
    chk("midrst_ack", 32'(upg_ack), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    drive(1'b1, 32'd40, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_run_en", 32'(mem_en), 32'd1);
    chk("midrst_run_addr", 32'(mem_addr), 32'd10);
    @(posedge clock); #1;
    chk("midrst_fetch_rdata", if_rdata, 32'h55);
    chk("midrst_fetch_stall", 32'(if_stall), 32'd0);

    // Address guard: write above MAX_WORD, then at MAX_WORD
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b1, 1'b0, 14'd0, 32'h0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 14'd16, 32'h77, 1'b0);
    #1;
    chk("guard16_mem_we", 32'(mem_we), 32'(!GUARD));
    @(posedge clock); #1;
    chk("guard16_ack", 32'(upg_ack), 32'(!GUARD));
    chk("guard16_cnt", 32'(upg_cnt), GUARD ? 32'd0 : 32'd1);
    chk("guard16_err", 32'(upg_err), 32'(GUARD));
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b1, 1'b1, 14'd15, 32'h88, 1'b0);
    #1;
    chk("guard15_mem_we", 32'(mem_we), 32'd1);
    @(posedge clock); #1;
    chk("guard15_ack", 32'(upg_ack), 32'd1);
    chk("guard15_cnt", 32'(upg_cnt), GUARD ? 32'd1 : 32'd2);
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 14'd0, 32'h0, 1'b1);
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0);
    @(negedge clock);
    @(posedge clock); #1;
    chk("guard_release_stall", 32'(if_stall), 32'd0);
    chk("guard_err_sticky", 32'(upg_err), 32'(GUARD));
    @(negedge clock);
    drive(1'b1, 32'd60, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0);
    @(negedge clock);
    drive(1'b1, 32'd64, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0);
    #1;
    chk("guard_fetch15", if_rdata, 32'h88);
    @(posedge clock); #1;
    chk("guard_fetch16", if_rdata, GUARD ? 32'h1616 : 32'h77);

    // Random run against the phase model
    @(negedge clock);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 14'd0, 32'h0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = env_mem[i];
    m_phase = 0; m_left = 0; m_pend = 1'b0; m_prev_req = 1'b0; m_err = 1'b0; m_cnt = 16'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      word = 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 3) != 0), {16'($urandom), 9'd0, word, 2'($urandom)},
            ($urandom_range(0, 15) == 0) ? !upg_req : upg_req,
            1'($urandom_range(0, 1)), 14'($urandom_range(0, 20)), $urandom,
            ($urandom_range(0, 19) == 0));
      #1;
      m_ok = !GUARD || (upg_addr <= MAXW);
      x_en = 1'b0; x_we = 1'b0; x_addr = 14'd0; x_ready = 1'b0; x_ack = 1'b0; x_rdata = 32'h0;
      if (m_phase == 0) begin
        x_en = if_req; x_addr = {9'd0, word};
      end else if (m_phase == 2) begin
        x_en = upg_wen && m_ok; x_we = x_en; x_addr = upg_addr;
      end
      chk("rnd_mem_en", 32'(mem_en), 32'(x_en));
      chk("rnd_mem_we", 32'(mem_we), 32'(x_we));
      chk("rnd_mem_addr", 32'(mem_addr), 32'(x_addr));
      if (x_we) chk("rnd_mem_wdata", mem_wdata, upg_wdata);
      case (m_phase)
        0: begin
          if (if_req) begin x_ready = 1'b1; x_rdata = ref_mem[word]; end
          if (upg_req) m_phase = 1;
        end
        1: begin m_cnt = 16'd0; m_err = 1'b0; m_phase = 2; end
        2: begin
          if (upg_wen && m_ok) begin
            ref_mem[upg_addr[4:0]] = upg_wdata; m_cnt = m_cnt + 16'd1; x_ack = 1'b1;
          end else if (upg_wen) m_err = 1'b1;
          if (upg_done || !upg_req) begin m_phase = 3; m_left = REL; m_pend = 1'b0; end
        end
        default: begin
          if (upg_req && !m_prev_req) m_pend = 1'b1;
          m_left = m_left - 1;
          if (m_left == 0) m_phase = m_pend ? 1 : 0;
        end
      endcase
      m_prev_req = upg_req;
      @(posedge clock); #1;
      chk("rnd_ready", 32'(if_ready), 32'(x_ready));
      if (x_ready) chk("rnd_rdata", if_rdata, x_rdata);
      chk("rnd_stall", 32'(if_stall), 32'(m_phase != 0));
      chk("rnd_cpurst", 32'(cpu_reset_o), 32'(m_phase != 0));
      chk("rnd_ack", 32'(upg_ack), 32'(x_ack));
      chk("rnd_cnt", 32'(upg_cnt), 32'(m_cnt));
      chk("rnd_err", 32'(upg_err), 32'(m_err));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Owner of the single port of the instruction memory, shared between the instruction-fetch unit and the UART program loader. In run mode it serves fetch reads at the PC every cycle. When a programming session starts, it drains the outstanding fetch read, stalls fetch, holds the CPU in reset and hands the port to the loader. When the loader signals done, it returns the port to fetch.

## Interface
Parameters:
- ADDR_W, 14: instruction-memory word-address width.
- MAX_WORD, 14'h3FFF: highest writable word address; used only under IMEM_WRITE_GUARD_EN.
- RELEASE_CYC, 2: cycles `cpu_reset_o` stays high after `upg_done`; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch wants the instruction at `if_addr`.
- if_addr  in  32  fetch byte address (PC); bits [1:0] ignored.
- if_ready  out  1  `if_rdata` is valid this cycle.
- if_rdata  out  32  fetched instruction (`mem_rdata` passed through).
- if_stall  out  1  fetch must hold its PC.
- upg_req  in  1  loader session active (level).
- upg_wen  in  1  loader write strobe, one word per cycle.
- upg_addr  in  ADDR_W  loader word address.
- upg_wdata  in  32  loader write data.
- upg_done  in  1  one-cycle pulse: loading finished.
- upg_ack  out  1  write accepted (one-cycle pulse).
- upg_cnt  out  16  words written in the current session; wraps at 16'hFFFF.
- upg_err  out  1  sticky guard violation (guard build only; tied 0 otherwise).
- cpu_reset_o  out  1  holds the CPU core in reset.
- mem_en, mem_we  out  1  memory enable and write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  synchronous read data, one-cycle latency.

## Operation
- The FSM has four states: RUN, DRAIN, PROG, RELEASE. Reset state is RUN.
- **RUN:**
  - Memory drive: `mem_en`=`if_req`, `mem_we`=0, `mem_addr`=`if_addr[ADDR_W+1:2]`.
  - `upg_req`=1 moves to DRAIN. The read issued in that same cycle is still honoured.
- **DRAIN:**
  - One cycle only. `if_stall`=1, `mem_en`=0, `cpu_reset_o`=1.
  - `upg_cnt` clears to 0. Next state is PROG.
- **PROG:**
  - Outputs: `if_stall`=1, `cpu_reset_o`=1.
  - Memory drive: `mem_en`=`mem_we`=`upg_wen`, `mem_addr`=`upg_addr`, `mem_wdata`=`upg_wdata`.
  - Each write pulses `upg_ack` on the next cycle and increments `upg_cnt`.
  - `upg_done`, or `upg_req` falling, moves to RELEASE. A write in the same cycle is still performed and counted.
- **RELEASE:**
  - `mem_en`=0, `if_stall`=1, `cpu_reset_o`=1 for RELEASE_CYC cycles, then RUN.
  - `upg_req` reasserting during RELEASE goes to DRAIN after the count completes.
- Fetch requests outside RUN are ignored: no memory access and no `if_ready`.
- `upg_wen` outside PROG is ignored: no write and no `upg_ack`.

## Timing
- Reset values:
  - All outputs are 0 except `if_rdata`, which follows `mem_rdata`.
  - `upg_cnt`=0, `upg_err`=0, state = RUN.
- Fetch latency: `if_req` accepted at edge N gives `if_ready`=1 during cycle N+1, with `if_rdata` valid. Back-to-back fetches sustain one per cycle.
- `if_stall` and `cpu_reset_o` are registered. They rise the cycle after `upg_req` is sampled high in RUN.
- `upg_ack` is registered, one cycle after the write edge.
- `cpu_reset_o` falls exactly RELEASE_CYC cycles after the RELEASE entry edge. `if_stall` falls with it.
- `reset` mid-session returns to RUN immediately and clears `upg_cnt`, `upg_err` and every registered output. Memory contents are untouched.

## Configuration
- **IMEM_WRITE_GUARD_EN defined:**
  - A PROG write with `upg_addr` > MAX_WORD is dropped: `mem_we`=0, no `upg_ack`, `upg_cnt` unchanged.
  - It sets `upg_err`, which stays set until `reset` or the next DRAIN.
- **Not defined:** every PROG write goes to memory and `upg_err` is constant 0.

## Test plan
- Reset, then `if_req`=1 with `if_addr`=0, 4, 8 on consecutive cycles (memory preloaded 32'hA, B, C) -> `if_ready` high from the cycle after the first request; `if_rdata`=A, B, C; `mem_addr`=0, 1, 2.
- Assert `upg_req` mid-fetch at `if_addr`=12 -> the read of word 3 completes (`if_ready`=1 next cycle); `if_stall` and `cpu_reset_o` high from then on; one DRAIN cycle with `mem_en`=0.
- In PROG, write 3 words to addresses 5, 6, 7 with data 1, 2, 3, then pulse `upg_done` together with the third write -> 3 `upg_ack` pulses; `upg_cnt`=3; `cpu_reset_o` low exactly 2 cycles after RELEASE entry; a subsequent fetch of byte 20 returns 1.
- Assert `reset` while in PROG after 2 writes -> same-cycle return to RUN; `upg_cnt`=0; `if_stall`=0; `cpu_reset_o`=0.
- Guard build with MAX_WORD=14'd15: write to address 16 -> no write and no ack; `upg_err`=1 and stays set. The next write to address 15 is accepted and `upg_cnt` increments.
- Pulse `upg_wen` in RUN -> `mem_we` stays 0, no `upg_ack`, `upg_cnt` unchanged.
